// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the write-back trace UART transmitter
package trace_pkg;

    // Transmit FSM states; IDLE is the only state in which the line is not busy
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Each 32-bit trace word goes out as four bytes, least-significant first
    localparam int   BYTES_PER_WORD = 4;

    // UART line levels
    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - circular word buffer with full/empty/count flags and drop-on-full
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    // A push into a full buffer is still accepted when a pop frees a slot on the same edge
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and sticky-overflow state; reset flushes the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// rtl/wb_trace_uart_tx.sv - captures write-back words and serializes them as UART 8N1 bytes
module wb_trace_uart_tx
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [31:0]                   WB_Data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    tx_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic        bit_end;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_dout;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wb_valid),
        .pop      (fifo_pop),
        .din      (WB_Data),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);

    // A word leaves the buffer when starting from idle, or back-to-back after the last stop bit
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                fifo_pop = 1'b1;
            end else if (state == STOP && bit_end && byte_idx == LAST_BYTE) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Transmit FSM; the shift register moves right one place per data bit so the
    // next byte is always sitting in the low eight bits when its frame starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx       <= UART_IDLE;
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        byte_idx <= '0;
                        tx       <= UART_START;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= UART_IDLE;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx       <= UART_START;
                            state    <= START;
                        end else if (!fifo_empty) begin
                            shreg    <= fifo_dout;
                            byte_idx <= '0;
                            tx       <= UART_START;
                            state    <= START;
                        end else begin
                            tx    <= UART_IDLE;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    tx    <= UART_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
